// File: rtl/mac_seq_divider.sv
// Sequential unsigned restoring divider: NW-bit dividend by DW-bit divisor, one quotient bit per clock.
// Valid/ready handshake on both sides; divide-by-zero returns all-ones quotient with dbz set.
module mac_seq_divider #(
    parameter int NW = 22,
    parameter int DW = 8,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          dbz
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          w_accept;
    logic          w_last_step;

    logic [CW-1:0] r_cnt;
    logic [NW-1:0] r_q;
    logic [DW:0]   r_r;
    logic [DW-1:0] r_dvs;
    logic [NW-1:0] r_quot;
    logic [DW-1:0] r_rem;
    logic          r_dbz;

    logic [DW:0]   w_rs;
    logic          w_ge;
    logic [DW:0]   w_r_step;
    logic [NW-1:0] w_q_step;

    // One restoring step: shift the next dividend bit into the partial remainder, subtract if it fits.
    assign w_rs     = (DW+1)'({r_r, r_q[NW-1]});
    assign w_ge     = (w_rs >= {1'b0, r_dvs});
    assign w_r_step = w_ge ? (w_rs - {1'b0, r_dvs}) : w_rs;
    assign w_q_step = {r_q[NW-2:0], w_ge};
    assign w_last_step = (r_cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = (divisor == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last_step) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Result registers are written only on entry to DONE so they hold across IDLE and RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_q    <= '0;
            r_r    <= '0;
            r_dvs  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
        end else if (w_accept) begin
            r_q   <= dividend;
            r_dvs <= divisor;
            r_r   <= '0;
            r_cnt <= CW'(NW);
            if (divisor == '0) begin
                r_quot <= '1;
                r_rem  <= '0;
                r_dbz  <= 1'b1;
            end
        end else if (r_state == S_RUN) begin
            r_q   <= w_q_step;
            r_r   <= w_r_step;
            r_cnt <= r_cnt - CW'(1);
            if (w_last_step) begin
                r_quot <= w_q_step;
                r_rem  <= w_r_step[DW-1:0];
                r_dbz  <= 1'b0;
            end
        end
    end

    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign dbz       = r_dbz;

endmodule

// File: tb/tb_mac_seq_divider.sv
// Self-checking bench for mac_seq_divider: directed corner cases, backpressure, async reset abort
// and randomized operations against an arithmetic (/ and %) reference.
module tb_mac_seq_divider;

    localparam int NW = 22;
    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [NW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [NW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic          dbz;

    int checks;
    int failures;

    logic [NW-1:0] prev_q;
    logic [DW-1:0] prev_r;
    logic          prev_dbz;

    mac_seq_divider #(.NW(NW), .DW(DW), .CW(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation from accept to retire; all driving/sampling happens 1ns after a rising edge.
    task automatic do_op(input logic [NW-1:0] a, input logic [DW-1:0] b, input int hold);
        int            n;
        int            lat;
        int            exp_lat;
        logic [NW-1:0] eq;
        logic [DW-1:0] er;
        logic          ed;

        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check_val("in_ready_before_accept", {31'd0, in_ready}, 32'd1);

        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        in_valid = 1'b0;
        dividend = NW'($urandom);
        divisor  = DW'($urandom);

        if (b == 0) begin
            eq = {NW{1'b1}};
            er = '0;
            ed = 1'b1;
            exp_lat = 0;
        end else begin
            eq = a / b;
            er = DW'(a % b);
            ed = 1'b0;
            exp_lat = NW;
        end

        lat = 0;
        while (!out_valid && lat < 60) begin
            check_val("run_hold_quotient", 32'(quotient), 32'(prev_q));
            check_val("run_hold_remainder", 32'(remainder), 32'(prev_r));
            check_val("run_in_ready_low", {31'd0, in_ready}, 32'd0);
            tick();
            lat++;
        end
        check_val("latency", lat, exp_lat);
        check_val("quotient", 32'(quotient), 32'(eq));
        check_val("remainder", 32'(remainder), 32'(er));
        check_val("dbz", {31'd0, dbz}, {31'd0, ed});

        for (int i = 0; i < hold; i++) begin
            tick();
            check_val("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check_val("bp_quotient", 32'(quotient), 32'(eq));
            check_val("bp_remainder", 32'(remainder), 32'(er));
            check_val("bp_dbz", {31'd0, dbz}, {31'd0, ed});
        end

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("retire_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("retire_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("retire_hold_quotient", 32'(quotient), 32'(eq));

        prev_q   = eq;
        prev_r   = er;
        prev_dbz = ed;
        $display("op dividend=%0d divisor=%0d quotient=%0d remainder=%0d dbz=%0b lat=%0d hold=%0d",
                 a, b, quotient, remainder, dbz, lat, hold);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check_val({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check_val({tag, "_quotient"}, 32'(quotient), 32'd0);
        check_val({tag, "_remainder"}, 32'(remainder), 32'd0);
        check_val({tag, "_dbz"}, {31'd0, dbz}, 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NW-1:0] ra;
        logic [DW-1:0] rb;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        prev_q    = '0;
        prev_r    = '0;
        prev_dbz  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        do_op(22'd100, 8'd7, 0);
        do_op(22'd4194303, 8'd255, 2);
        do_op(22'd4194303, 8'd1, 0);
        do_op(22'd0, 8'd5, 0);
        do_op(22'd3, 8'd200, 0);
        do_op(22'd1234, 8'd0, 1);
        do_op(22'd5000, 8'd13, 10);
        do_op(22'd999, 8'd9, 0);

        // Abort an operation with reset at step 10 of RUN, off the clock edge.
        in_valid = 1'b1;
        dividend = 22'd1000;
        divisor  = 8'd3;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        prev_q   = '0;
        prev_r   = '0;
        prev_dbz = 1'b0;
        @(negedge clk);
        check_reset_state("reset_held");
        rst_n = 1'b1;
        tick();
        check_reset_state("after_release");
        do_op(22'd57, 8'd8, 0);

        for (int i = 0; i < 2500; i++) begin
            case ($urandom_range(9))
                0: rb = 8'd0;
                1: rb = 8'd1;
                2: rb = 8'd255;
                default: rb = DW'($urandom);
            endcase
            case ($urandom_range(7))
                0: ra = '1;
                1: ra = '0;
                2: ra = NW'($urandom_range(255));
                default: ra = NW'($urandom);
            endcase
            do_op(ra, rb, ($urandom_range(3) == 0) ? $urandom_range(3) : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
